ppc_seg_display: RTL and testbench

PPC_SEG_DISPLAY -- requirements
Module: ppc_seg_display

---
 rtl/ppc_seg_display.sv | 151 +++++++++++++++
 tb/tb_ppc_seg_display.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/ppc_seg_display.sv
// ppc_seg_display: 4-digit multiplexed, common-anode 7-segment driver for a
// ping-pong counter. count_in is split into decimal digits 1/0. The upper
// digits depend on the build option PPC_BOUNCE_CNT_EN:
//   undefined: digit 3 shows U (up) or d (down), and digit 2 is blank.
//   defined  : digits 3/2 show a BCD count (00..99) of direction reversals,
//              and the digit-0 decimal point is lit while counting up.
module ppc_seg_display #(
   parameter int REFRESH_BITS = 17
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] count_in,
   input  logic       dir_in,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp
);
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_UP    = 7'b1000001;
   localparam logic [6:0] SEG_DN    = 7'b0100001;

   logic [3:0]              count_q;
   logic                    dir_q;
   logic [REFRESH_BITS-1:0] scan_cnt;
   logic [1:0]              digit_sel;
   logic                    scan_tick;
   logic [3:0]              count_units;
   logic [3:0]              an_nxt;
   logic [6:0]              seg_nxt;
   logic                    dp_nxt;

   function automatic logic [6:0] glyph(input logic [3:0] v);
      case (v)
         4'd0:    glyph = 7'b1000000;
         4'd1:    glyph = 7'b1111001;
         4'd2:    glyph = 7'b0100100;
         4'd3:    glyph = 7'b0110000;
         4'd4:    glyph = 7'b0011001;
         4'd5:    glyph = 7'b0010010;
         4'd6:    glyph = 7'b0000010;
         4'd7:    glyph = 7'b1111000;
         4'd8:    glyph = 7'b0000000;
         4'd9:    glyph = 7'b0010000;
         default: glyph = SEG_BLANK;
      endcase
   endfunction

   assign scan_tick   = &scan_cnt;
   assign count_units = (count_q >= 4'd10) ? count_q - 4'd10 : count_q;

   // Capture the upstream count and direction every cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= 4'd0;
         dir_q   <= 1'b1;
      end else begin
         count_q <= count_in;
         dir_q   <= dir_in;
      end
   end

   // Free-running refresh counter; its all-ones tick steps the digit select.
   always_ff @(posedge clk) begin
      if (rst) begin
         scan_cnt  <= '0;
         digit_sel <= 2'd0;
      end else begin
         scan_cnt <= scan_cnt + 1'b1;
         if (scan_tick) digit_sel <= digit_sel + 2'd1;
      end
   end

`ifdef PPC_BOUNCE_CNT_EN
   logic       dir_prev;
   logic       rev_evt;
   logic       pass_start;
   logic [3:0] rev_tens;
   logic [3:0] rev_units;
   logic [3:0] disp_tens;
   logic [3:0] disp_units;

   assign rev_evt    = dir_q != dir_prev;
   assign pass_start = scan_tick && (digit_sel == 2'd3);

   // BCD reversal counter (00..99, wraps), fed by the direction-change flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         dir_prev  <= 1'b1;
         rev_tens  <= 4'd0;
         rev_units <= 4'd0;
      end else begin
         dir_prev <= dir_q;
         if (rev_evt) begin
            if (rev_units == 4'd9) begin
               rev_units <= 4'd0;
               rev_tens  <= (rev_tens == 4'd9) ? 4'd0 : rev_tens + 4'd1;
            end else begin
               rev_units <= rev_units + 4'd1;
            end
         end
      end
   end

   // Snapshot the count once per pass so tens and units always come from the
   // same value; an increment landing on the wrap tick shows on the next pass.
   always_ff @(posedge clk) begin
      if (rst) begin
         disp_tens  <= 4'd0;
         disp_units <= 4'd0;
      end else if (pass_start) begin
         disp_tens  <= rev_tens;
         disp_units <= rev_units;
      end
   end
`endif

   // Digit enable, glyph and decimal point for the currently selected digit.
   always_comb begin
      an_nxt            = 4'b1111;
      an_nxt[digit_sel] = 1'b0;
      seg_nxt           = SEG_BLANK;
      dp_nxt            = 1'b1;
      case (digit_sel)
         2'd0: seg_nxt = glyph(count_units);
         2'd1: seg_nxt = (count_q >= 4'd10) ? glyph(4'd1) : SEG_BLANK;
`ifdef PPC_BOUNCE_CNT_EN
         2'd2: seg_nxt = glyph(disp_units);
         2'd3: seg_nxt = glyph(disp_tens);
`else
         2'd2: seg_nxt = SEG_BLANK;
         2'd3: seg_nxt = dir_q ? SEG_UP : SEG_DN;
`endif
      endcase
`ifdef PPC_BOUNCE_CNT_EN
      if (digit_sel == 2'd0 && dir_q) dp_nxt = 1'b0;
`endif
   end

   // Registered display outputs; reset blanks the whole display.
   always_ff @(posedge clk) begin
      if (rst) begin
         an  <= 4'b1111;
         seg <= SEG_BLANK;
         dp  <= 1'b1;
      end else begin
         an  <= an_nxt;
         seg <= seg_nxt;
         dp  <= dp_nxt;
      end
   end
endmodule

// File: tb/tb_ppc_seg_display.sv
// Bench for ppc_seg_display with a short refresh period. The reference model
// derives every expected output from the cycle index since reset and the
// recorded input history.
module tb_ppc_seg_display;
   localparam int RB   = 2;
   localparam int P    = 1 << RB;
   localparam int HMAX = 4096;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] count_in;
   logic       dir_in;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;

   int checks   = 0;
   int failures = 0;
   int cin_h [HMAX];
   int dir_h [HMAX];
   int n;
   logic [6:0] glyph_tab [10];

   ppc_seg_display #(.REFRESH_BITS(RB)) dut (
      .clk      (clk),
      .rst      (rst),
      .count_in (count_in),
      .dir_in   (dir_in),
      .an       (an),
      .seg      (seg),
      .dp       (dp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         failures++;
         $display("FAIL %s (n=%0d): got %0b expected %0b", tag, n, obs, exp_v);
      end
   endtask

   // Reversals counted before edge m: dir sampled at edge i against the
   // previous sample (the reset value 1 before edge 0).
   function automatic int rev_before(input int m);
      int c;
      int prev;
      c    = 0;
      prev = 1;
      for (int i = 0; i <= m - 2; i++) begin
         if (dir_h[i] != prev) c++;
         prev = dir_h[i];
      end
      return c;
   endfunction

   task automatic check_cycle();
      int cq, dq, d, v;
      logic [3:0] ean;
      logic [6:0] eseg;
      logic       edp;
      cq   = (n == 0) ? 0 : cin_h[n-1];
      dq   = (n == 0) ? 1 : dir_h[n-1];
      d    = (n / P) % 4;
      ean  = 4'b1111;
      ean[d] = 1'b0;
      eseg = 7'b1111111;
      edp  = 1'b1;
      if (d == 0) eseg = glyph_tab[cq % 10];
      if (d == 1 && cq >= 10) eseg = glyph_tab[1];
`ifdef PPC_BOUNCE_CNT_EN
      v = ((n / (4*P)) == 0) ? 0 : rev_before(4*P*(n / (4*P)) - 1) % 100;
      if (d == 2) eseg = glyph_tab[v % 10];
      if (d == 3) eseg = glyph_tab[v / 10];
      if (d == 0 && dq == 1) edp = 1'b0;
`else
      v = 0;
      if (d == 3) eseg = (dq == 1) ? 7'b1000001 : 7'b0100001;
`endif
      chk("an",  32'(an),  32'(ean));
      chk("seg", 32'(seg), 32'(eseg));
      chk("dp",  32'(dp),  32'(edp));
   endtask

   task automatic step(input logic [3:0] c, input logic d);
      count_in = c;
      dir_in   = d;
      cin_h[n] = int'(c);
      dir_h[n] = int'(d);
      @(posedge clk);
      #1;
      check_cycle();
      n++;
   endtask

   task automatic do_reset(input int cyc);
      rst = 1'b1;
      for (int i = 0; i < cyc; i++) begin
         @(posedge clk);
         #1;
         chk("rst_an",  32'(an),  32'h0000000F);
         chk("rst_seg", 32'(seg), 32'h0000007F);
         chk("rst_dp",  32'(dp),  32'h00000001);
      end
      rst = 1'b0;
      n   = 0;
   endtask

   initial begin
      logic [3:0] c;
      logic       d;
      glyph_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
      rst      = 1'b1;
      count_in = 4'd0;
      dir_in   = 1'b1;
      n        = 0;

      do_reset(3);
      step(4'd13, 1'b1);
      chk("first_an",  32'(an),  32'h0000000E);
      chk("first_seg", 32'(seg), 32'b1000000);

      // Decimal split and direction glyphs, held over two full passes.
      for (int i = 0; i < 8*P; i++) step(4'd13, 1'b1);
      for (int i = 0; i < 8*P; i++) step(4'd7, 1'b1);
      for (int i = 0; i < 8*P; i++) step(4'd15, 1'b0);
      for (int i = 0; i < 8*P; i++) step(4'd10, 1'b1);

      // Reversal bursts: 12 toggles, then 100 more (count mod 100 unchanged).
      d = 1'b1;
      for (int i = 0; i < 12; i++) begin d = ~d; step(4'd9, d); end
      for (int i = 0; i < 12*P; i++) step(4'd9, d);
      for (int i = 0; i < 100; i++) begin d = ~d; step(4'd0, d); end
      for (int i = 0; i < 12*P; i++) step(4'd0, d);

      // Randomized traffic with slowly varying inputs.
      c = 4'd5;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(7) == 0) c = 4'($urandom_range(15));
         if ($urandom_range(5) == 0) d = ~d;
         step(c, d);
      end

      // Mid-scan reset after 37 reversals from a fresh start.
      do_reset(2);
      d = 1'b1;
      for (int i = 0; i < 37; i++) begin d = ~d; step(4'd3, d); end
      for (int i = 0; i < 8*P + 3; i++) step(4'd3, d);
      do_reset(1);
      step(4'd3, d);
      chk("restart_an", 32'(an), 32'h0000000E);
      for (int i = 0; i < 8*P; i++) step(4'd3, d);

      // Reset with dir_in low: first captured sample is a reversal.
      do_reset(1);
      for (int i = 0; i < 12*P; i++) begin
         if ($urandom_range(3) == 0) c = 4'($urandom_range(15));
         step(c, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
